// File: rtl/trilat_select.sv
// trilat_select: resolve the two-candidate intersection against anchor A by smallest |d^2 - rA^2|
module trilat_select #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [14*N+33:0]       cand_in,
    input  logic [3*N:0]           a_input,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [4*N+9:0]  x_out,
    output logic signed [3*N+6:0]  y_out,
    output logic                   sel,
    output logic [8*N+23:0]        err_out
);
    localparam int XW = 4*N+10;
    localparam int YW = 3*N+7;
    localparam int DW = 4*N+11;
    localparam int PW = 8*N+22;
    localparam int AW = 8*N+23;
    localparam int EW = 8*N+24;
    localparam int RW = 2*N+2;

    typedef enum logic [2:0] {IDLE, RA, D1X, D1Y, D2X, D2Y, CMP, DONE} state_t;

    state_t state_q, state_d;
    logic signed [XW-1:0] x1_q, x2_q;
    logic signed [YW-1:0] y1_q, y2_q;
    logic signed [N-1:0]  xa_q, ya_q;
    logic signed [N:0]    ra_q;
    logic [RW-1:0]        rsq_q;
    logic [AW-1:0]        acc1_q, acc2_q;
    logic signed [XW-1:0] x_out_q;
    logic signed [YW-1:0] y_out_q;
    logic                 sel_q;
    logic [EW-1:0]        err_q;

    logic signed [DW-1:0] dx1, dx2, mul_op;
    logic signed [YW:0]   dy1, dy2;
    logic signed [PW-1:0] prod;
    logic [AW-1:0]        sq;
    logic signed [EW-1:0] d1, d2;
    logic [EW-1:0]        e1, e2;

    assign dx1 = DW'(x1_q) - DW'(xa_q);
    assign dx2 = DW'(x2_q) - DW'(xa_q);
    assign dy1 = (YW+1)'(y1_q) - (YW+1)'(ya_q);
    assign dy2 = (YW+1)'(y2_q) - (YW+1)'(ya_q);

    // shared squarer: pick the one operand this state needs
    always_comb begin
        mul_op = (state_q == RA)  ? DW'(ra_q) :
                 (state_q == D1X) ? dx1 :
                 (state_q == D1Y) ? DW'(dy1) :
                 (state_q == D2X) ? dx2 : DW'(dy2);
    end

    assign prod = PW'(mul_op) * PW'(mul_op);
    assign sq   = AW'($unsigned(prod));
    assign d1   = $signed({1'b0, acc1_q}) - $signed(EW'(rsq_q));
    assign d2   = $signed({1'b0, acc2_q}) - $signed(EW'(rsq_q));
    assign e1   = d1[EW-1] ? $unsigned(-d1) : $unsigned(d1);
    assign e2   = d2[EW-1] ? $unsigned(-d2) : $unsigned(d2);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // fixed step sequence; only IDLE and DONE wait on a handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? RA : IDLE;
            RA:      state_d = D1X;
            D1X:     state_d = D1Y;
            D1Y:     state_d = D2X;
            D2X:     state_d = D2Y;
            D2Y:     state_d = CMP;
            CMP:     state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // capture job, accumulate squared distances, then latch the winning candidate
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            ra_q    <= '0;
            rsq_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            sel_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    {x1_q, y1_q, x2_q, y2_q} <= cand_in;
                    {xa_q, ya_q, ra_q}       <= a_input;
                end
                RA:  rsq_q  <= RW'(sq);
                D1X: acc1_q <= sq;
                D1Y: acc1_q <= acc1_q + sq;
                D2X: acc2_q <= sq;
                D2Y: acc2_q <= acc2_q + sq;
                CMP: begin
                    x_out_q <= (e2 < e1) ? x2_q : x1_q;
                    y_out_q <= (e2 < e1) ? y2_q : y1_q;
                    sel_q   <= (e2 < e1);
                    err_q   <= (e2 < e1) ? e2 : e1;
                end
                default: ;
            endcase
        end
    end

    assign x_out   = x_out_q;
    assign y_out   = y_out_q;
    assign sel     = sel_q;
    assign err_out = err_q;
endmodule

// File: tb/tb_trilat_select.sv
// tb_trilat_select: randomized scoreboard bench for trilat_select against an arithmetic reference
module tb_trilat_select;
    logic clk = 0;
    logic rst, in_valid, in_ready, out_valid, out_ready, sel;
    logic [145:0] cand_in;
    logic [24:0] a_input;
    logic signed [41:0] x_out;
    logic signed [30:0] y_out;
    logic [87:0] err_out;

    trilat_select #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cand_in(cand_in), .a_input(a_input), .out_valid(out_valid),
        .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .sel(sel), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [41:0] x;
        logic signed [30:0] y;
        logic s;
        logic [87:0] err;
        int due;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int hs_cyc = 0;
    bit prev_v = 0;
    bit bp = 0;
    bit rnd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference: squared distances in wide plain arithmetic, pick smaller error, tie to candidate 1
    function automatic exp_t model(input logic [145:0] c, input logic [24:0] a);
        logic signed [127:0] x1, y1, x2, y2, xa, ya, ra, dd1, dd2, rs, er1, er2;
        exp_t e;
        x1 = $signed(c[145:104]);
        y1 = $signed(c[103:73]);
        x2 = $signed(c[72:31]);
        y2 = $signed(c[30:0]);
        xa = $signed(a[24:17]);
        ya = $signed(a[16:9]);
        ra = $signed(a[8:0]);
        dd1 = (x1 - xa) * (x1 - xa) + (y1 - ya) * (y1 - ya);
        dd2 = (x2 - xa) * (x2 - xa) + (y2 - ya) * (y2 - ya);
        rs = ra * ra;
        er1 = dd1 - rs;
        er2 = dd2 - rs;
        if (er1 < 0) er1 = -er1;
        if (er2 < 0) er2 = -er2;
        e.s = (er2 < er1);
        e.x = e.s ? c[72:31] : c[145:104];
        e.y = e.s ? c[30:0] : c[103:73];
        e.err = e.s ? er2[87:0] : er1[87:0];
        e.due = 0;
        return e;
    endfunction

    function automatic logic [145:0] pk(input longint x1, input longint y1, input longint x2, input longint y2);
        return {x1[41:0], y1[30:0], x2[41:0], y2[30:0]};
    endfunction

    function automatic logic [24:0] pa(input int xa, input int ya, input int ra);
        return {xa[7:0], ya[7:0], ra[8:0]};
    endfunction

    function automatic logic [145:0] rand_cand();
        logic [159:0] w;
        longint v[4];
        if ($urandom_range(0, 1) == 0) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            return w[145:0];
        end
        for (int i = 0; i < 4; i++) v[i] = longint'($urandom_range(0, 60)) - 30;
        return pk(v[0], v[1], v[2], v[3]);
    endfunction

    // output pacing: changed just after the edge so the monitor sees a settled value
    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // monitor: compare presented result with the scoreboard head, pop on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                if (!prev_v) chk("latency", 128'(cyc), 128'(q[0].due));
                chk("x_out", x_out, q[0].x);
                chk("y_out", y_out, q[0].y);
                chk("sel", sel, q[0].s);
                chk("err_out", err_out, q[0].err);
                chk("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    void'(q.pop_front());
                    hs_cyc = cyc;
                end
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [145:0] c, input logic [24:0] a, input bit push, output int k);
        int t;
        exp_t e;
        @(negedge clk);
        cand_in = c;
        a_input = a;
        in_valid = 1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 0;
            k = -1;
            return;
        end
        k = cyc;
        @(posedge clk);
        if (push) begin
            e = model(c, a);
            e.due = k + 7;
            q.push_back(e);
        end
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_x_out"}, x_out, 0);
        chk({nm, "_y_out"}, y_out, 0);
        chk({nm, "_sel"}, sel, 0);
        chk({nm, "_err_out"}, err_out, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k, k2, t;
        longint big;
        rst = 1;
        in_valid = 0;
        cand_in = '0;
        a_input = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 0;

        send(pk(3, 4, 6, 8), pa(0, 0, 5), 1, k);
        send(pk(6, 8, 3, 4), pa(0, 0, 5), 1, k);
        send(pk(3, 4, 3, -4), pa(0, 0, 5), 1, k);
        send(pk(127, 127, -128, -128), pa(-128, -128, 0), 1, k);
        send(pk(127, 127, 127, 127), pa(-128, -128, 0), 1, k);
        big = -(longint'(1) << 41);
        send(pk(big, -(longint'(1) << 30), (longint'(1) << 41) - 1, (longint'(1) << 30) - 1),
             pa(127, 127, 255), 1, k);
        send(pk(-5, 0, 0, 7), pa(-1, 2, 255), 1, k);
        drain();

        bp = 1;
        send(pk(10, -3, -7, 12), pa(4, -9, 11), 1, k);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach_done", out_valid, 1);
        fork
            send(pk(1, 2, 3, 4), pa(0, 0, 3), 1, k2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid_held", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                end
                bp = 0;
            end
        join
        chk("accept_after_handshake", 128'(k2), 128'(hs_cyc + 1));
        drain();

        send(pk(20, 20, -20, 5), pa(3, 3, 9), 0, k);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_reset_state("midreset");
        rst = 0;
        repeat (12) @(negedge clk);
        chk("midreset_no_valid", out_valid, 0);
        send(pk(6, 8, 3, 4), pa(0, 0, 5), 1, k);
        drain();

        rnd = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rand_cand(), {$urandom_range(0, 255) % 256 == 0 ? 8'd0 : 8'($urandom()), 8'($urandom()),
                               9'($urandom_range(0, 255))}, 1, k);
        end
        rnd = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
